// File: rtl/mac_unit_wave_seq.sv
// Self-sequencing bit-serial dot-product MAC: one latched activation vector, weight columns MSB-first.
// Optional build macro MAC_WAVE_SEQ_SAT_EN: saturate result to the signed RESULT_WIDTH range and raise ovf.
module mac_unit_wave_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 8,
  parameter int W_PREC       = 8,
  parameter int ACC_WIDTH    = DATA_WIDTH + 16,
  parameter int RESULT_WIDTH = 16,
  localparam int PREC_W      = $clog2(W_PREC + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  output logic                               start_ready,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0]   act_in,
  input  logic                               load_accum,
  input  logic [ACC_WIDTH-1:0]               accum_prev,
  input  logic [PREC_W-1:0]                  prec,
  input  logic                               col_valid,
  output logic                               col_ready,
  input  logic [VEC_LENGTH-1:0]              w_bit,
  input  logic [VEC_LENGTH-1:0]              sign,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [RESULT_WIDTH-1:0]            result,
  output logic [ACC_WIDTH-1:0]               accum_out,
  output logic                               ovf
);

  localparam int SUM_W = DATA_WIDTH + 1 + $clog2(VEC_LENGTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          state, state_next;
  logic [DATA_WIDTH*VEC_LENGTH-1:0] act_reg;
  logic [PREC_W-1:0]               col_cnt, prec_res;
  logic signed [ACC_WIDTH-1:0]     acc, psum_reg, psum_next;
  logic                            psum_vld;
  logic signed [DATA_WIDTH:0]      term [VEC_LENGTH];
  logic signed [SUM_W-1:0]         lane_sum;
  logic                            start_fire, beat;

  assign start_fire = start && start_ready;
  assign beat       = col_valid && col_ready;

  // Out-of-range precision (0 or above W_PREC) means full precision.
  assign prec_res = (prec == '0 || prec > PREC_W'(W_PREC)) ? PREC_W'(W_PREC - 1)
                                                         : prec - PREC_W'(1);

  // Lane terms are widened by one bit before negation so -(-2^(DATA_WIDTH-1)) is exact.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      term[i] = {act_reg[i*DATA_WIDTH+DATA_WIDTH-1], act_reg[i*DATA_WIDTH +: DATA_WIDTH]};
      if (sign[i]) term[i] = -term[i];
      if (!w_bit[i]) term[i] = '0;
      lane_sum = lane_sum + {{(SUM_W-DATA_WIDTH-1){term[i][DATA_WIDTH]}}, term[i]};
    end
    psum_next = {{(ACC_WIDTH-SUM_W){lane_sum[SUM_W-1]}}, lane_sum} <<< col_cnt;
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    col_ready   = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        col_ready = 1'b1;
        if (col_valid && col_cnt == '0) state_next = DRAIN;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      // NOTE: the activation register is small and is cleared so nothing leaks across a reset.
      act_reg  <= '0;
      col_cnt  <= '0;
      acc      <= '0;
      psum_reg <= '0;
      psum_vld <= 1'b0;
    end else begin
      state <= state_next;
      if (start_fire) begin
        act_reg <= act_in;
        acc     <= load_accum ? $signed(accum_prev) : '0;
      end else if (psum_vld) begin
        acc <= acc + psum_reg;
      end
      if (start_fire) begin
        col_cnt <= prec_res;
      end else if (beat && col_cnt != '0) begin
        col_cnt <= col_cnt - PREC_W'(1);
      end
      if (beat) begin
        psum_reg <= psum_next;
        psum_vld <= 1'b1;
      end else begin
        psum_vld <= 1'b0;
      end
    end
  end

  assign accum_out = acc;

`ifdef MAC_WAVE_SEQ_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] R_MAX =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] R_MIN =
    {{(ACC_WIDTH-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};
  logic sat_hi, sat_lo;
  assign sat_hi = acc > R_MAX;
  assign sat_lo = acc < R_MIN;
  assign result = sat_hi ? {1'b0, {(RESULT_WIDTH-1){1'b1}}} :
                  sat_lo ? {1'b1, {(RESULT_WIDTH-1){1'b0}}} :
                           acc[RESULT_WIDTH-1:0];
  assign ovf    = (state == DONE) && (sat_hi || sat_lo);
`else
  assign result = acc[ACC_WIDTH-1 -: RESULT_WIDTH];
  assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_mac_unit_wave_seq.sv
// Directed bench for mac_unit_wave_seq (default parameters: 8 lanes, 8-bit acts, 24-bit accumulator).
module tb_mac_unit_wave_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        start_ready;
  logic [63:0] act_in;
  logic        load_accum;
  logic [23:0] accum_prev;
  logic [3:0]  prec;
  logic        col_valid;
  logic        col_ready;
  logic [7:0]  w_bit;
  logic [7:0]  sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [23:0] accum_out;
  logic        ovf;

  logic [7:0]  cols [16];
  int          n_checks = 0;
  int          n_pass   = 0;

  mac_unit_wave_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_ready(start_ready),
    .act_in(act_in), .load_accum(load_accum), .accum_prev(accum_prev), .prec(prec),
    .col_valid(col_valid), .col_ready(col_ready), .w_bit(w_bit), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .accum_out(accum_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_result(input logic [23:0] a);
`ifdef MAC_WAVE_SEQ_SAT_EN
    if ($signed(a) > 24'sd32767) return 16'h7fff;
    if ($signed(a) < -24'sd32768) return 16'h8000;
    return a[15:0];
`else
    return a[23:8];
`endif
  endfunction

  function automatic logic exp_ovf(input logic [23:0] a);
`ifdef MAC_WAVE_SEQ_SAT_EN
    return ($signed(a) > 24'sd32767) || ($signed(a) < -24'sd32768);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_cols(input logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7);
    cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
    cols[4] = c4; cols[5] = c5; cols[6] = c6; cols[7] = c7;
    for (int i = 8; i < 16; i++) cols[i] = 8'h00;
  endtask

  // col_valid is offered every cycle (except the gap) so surplus beat acceptance shows up.
  task automatic run_op(input string tag, input logic [63:0] acts, input logic [3:0] p,
                        input logic ld, input logic [23:0] prev, input logic [7:0] sg,
                        input int exp_beats, input int gap_at, input int gap_len,
                        input int hold, input logic [23:0] exp_acc, input int exp_lat);
    int cyc, b, g;
    logic acc_beat;
    @(negedge clk);
    check({tag, " start_ready"}, start_ready, 1'b1);
    start = 1'b1; act_in = acts; prec = p; load_accum = ld; accum_prev = prev; sign = sg;
    @(posedge clk);
    cyc = 0; b = 0; g = 0;
    while (cyc < 64) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) break;
      if (b == gap_at && g < gap_len) begin
        col_valid = 1'b0;
        g++;
      end else begin
        col_valid = 1'b1;
        w_bit = cols[b & 15];
      end
      acc_beat = col_valid && col_ready;
      @(posedge clk);
      cyc++;
      if (acc_beat) b++;
    end
    col_valid = 1'b0;
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " beats"}, b, exp_beats);
    check({tag, " accum_out"}, accum_out, exp_acc);
    check({tag, " result"}, result, exp_result(exp_acc));
    check({tag, " ovf"}, ovf, exp_ovf(exp_acc));
    check({tag, " col_ready in DONE"}, col_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold out_valid"}, out_valid, 1'b1);
      check({tag, " hold accum_out"}, accum_out, exp_acc);
      check({tag, " hold result"}, result, exp_result(exp_acc));
      check({tag, " hold start_ready"}, start_ready, 1'b0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 1'b0);
    check({tag, " start_ready after handshake"}, start_ready, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; act_in = '0; load_accum = 1'b0; accum_prev = '0;
    prec = '0; col_valid = 1'b0; w_bit = '0; sign = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset start_ready", start_ready, 1'b1);
    check("reset col_ready", col_ready, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 16'h0);
    check("reset accum_out", accum_out, 24'h0);
    check("reset ovf", ovf, 1'b0);
    reset_n = 1'b1;

    set_cols(8'hff, 0, 0, 0, 0, 0, 0, 0);
    run_op("ones", {8{8'h01}}, 4'd1, 1'b0, 24'h0, 8'h00, 1, 99, 0, 0, 24'd8, 2);
    run_op("neg_min", {8{8'h80}}, 4'd1, 1'b0, 24'h0, 8'hff, 1, 99, 0, 0, 24'd1024, 2);

    set_cols(8'h01, 0, 0, 0, 0, 0, 0, 8'h01);
    run_op("p8", 64'h3, 4'd8, 1'b0, 24'h0, 8'h00, 8, 99, 0, 0, 24'd387, 9);
    run_op("p8_gap", 64'h3, 4'd8, 1'b0, 24'h0, 8'h00, 8, 4, 2, 0, 24'd387, 11);

    set_cols(8'h01, 8'h01, 0, 0, 0, 0, 0, 0);
    run_op("chain", 64'h5, 4'd2, 1'b1, -24'sd100, 8'h00, 2, 99, 0, 3, -24'sd85, 3);

    set_cols(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    for (int i = 8; i < 16; i++) cols[i] = 8'h01;
    run_op("prec0", 64'h1, 4'd0, 1'b0, 24'h0, 8'h00, 8, 99, 0, 0, 24'd255, 9);

    // Reset mid-RUN after three accepted beats.
    @(negedge clk);
    start = 1'b1; act_in = 64'h7; prec = 4'd8; load_accum = 1'b1; accum_prev = 24'd500;
    @(negedge clk);
    start = 1'b0; col_valid = 1'b1; w_bit = 8'h01;
    repeat (3) @(negedge clk);
    check("mid-run col_ready", col_ready, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async reset start_ready", start_ready, 1'b1);
    check("async reset col_ready", col_ready, 1'b0);
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset accum_out", accum_out, 24'h0);
    check("async reset result", result, 16'h0);
    check("async reset ovf", ovf, 1'b0);
    col_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post reset start_ready", start_ready, 1'b1);

    set_cols(8'hff, 0, 0, 0, 0, 0, 0, 0);
    run_op("after reset", {8{8'h02}}, 4'd1, 1'b0, 24'h0, 8'h0f, 1, 99, 0, 0, 24'd0, 2);

`ifdef MAC_WAVE_SEQ_SAT_EN
    set_cols(8'h00, 0, 0, 0, 0, 0, 0, 0);
    run_op("sat hi", 64'h0, 4'd1, 1'b1, 24'h100000, 8'h00, 1, 99, 0, 0, 24'h100000, 2);
    check("sat hi literal", exp_result(24'h100000), 16'd32767);
    run_op("sat pass", 64'h0, 4'd1, 1'b1, -24'sd5, 8'h00, 1, 99, 0, 0, -24'sd5, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
